mux_share_arbiter: RTL and testbench



---
 rtl/mux_share_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mux_share_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin arbiter/sequencer sharing one 4-input one-hot
// mux and its capture register among four requesters (A..D).
//
// Optional feature macro: MUX_ARB_LOCK_EN
//   defined   -> adds input LOCK; LOCK=1 in the ACK cycle keeps PTR on the
//                winner so a still-requesting source wins again (bursts).
//   undefined -> no LOCK port; PTR always advances past the winner.
//
// Bit order: REQ, GNT and SEL all use the same one-hot layout,
//   bit 3 = source A, bit 2 = B, bit 1 = C, bit 0 = D.
// Source indices (PTR, winner, SRC) are A=0, B=1, C=2, D=3.
//
// Ports:
//   CLK            clock, rising edge
//   R              synchronous active-high reset
//   LOCK           (MUX_ARB_LOCK_EN only) hold priority on current winner
//   REQ[3:0]       per-source request
//   DA/DB/DC/DD    source data words
//   SEL[3:0]       registered one-hot mux select (0 = none)
//   GNT[3:0]       one-cycle grant pulse to the winner
//   VALID          one-cycle pulse, Q updated
//   Q              captured data word
//   SRC[1:0]       index of the source captured in Q
//   BUSY           high whenever the sequencer is not idle
module mux_share_arbiter #(
  parameter int unsigned WORD       = 10,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic            CLK,
  input  logic            R,
`ifdef MUX_ARB_LOCK_EN
  input  logic            LOCK,
`endif
  input  logic [3:0]      REQ,
  input  logic [WORD-1:0] DA,
  input  logic [WORD-1:0] DB,
  input  logic [WORD-1:0] DC,
  input  logic [WORD-1:0] DD,
  output logic [3:0]      SEL,
  output logic [3:0]      GNT,
  output logic            VALID,
  output logic [WORD-1:0] Q,
  output logic [1:0]      SRC,
  output logic            BUSY
);

  localparam int unsigned NSRC  = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sel_q, sel_d;
  logic [3:0]         gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [WORD-1:0]    q_q, q_d;
  logic [1:0]         src_q, src_d;
  logic               busy_q, busy_d;

  logic [NSRC-1:0]    req_src;
  logic [1:0]         cand;
  logic [1:0]         pick_idx;
  logic               pick_found;
  logic [WORD-1:0]    mux_data;

  // Source index -> one-hot position (A is the MSB).
  function automatic logic [3:0] src_onehot(input logic [1:0] idx);
    src_onehot = 4'b1000 >> idx;
  endfunction

  // Re-index requests by source number so the scan works on indices.
  always_comb begin
    req_src = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      req_src[i] = REQ[int'(NSRC) - 1 - i];
    end
  end

  // Round-robin pick: first requesting source scanning PTR, PTR+1, ... mod 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    for (int k = 0; k < int'(NSRC); k++) begin
      cand = ptr_q + 2'(k);
      if (!pick_found && req_src[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Shared arrayed one-hot mux, driven from the registered select.
  assign mux_data = ({WORD{sel_q[3]}} & DA) |
                    ({WORD{sel_q[2]}} & DB) |
                    ({WORD{sel_q[1]}} & DC) |
                    ({WORD{sel_q[0]}} & DD);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    q_d     = q_q;
    src_d   = src_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          sel_d   = src_onehot(pick_idx);
          cnt_d   = CNT_W'(SETTLE_CYC);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // SEL stays constant here, so the mux output is settled at capture.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          q_d     = mux_data;
          src_d   = win_q;
          gnt_d   = src_onehot(win_q);
          valid_d = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        sel_d   = '0;
`ifdef MUX_ARB_LOCK_EN
        ptr_d   = LOCK ? win_q : win_q + 2'd1;
`else
        ptr_d   = win_q + 2'd1;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register; reset aborts any transaction without GNT/VALID.
  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      q_q     <= '0;
      src_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
    end
  end

  assign SEL   = sel_q;
  assign GNT   = gnt_q;
  assign VALID = valid_q;
  assign Q     = q_q;
  assign SRC   = src_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Testbench for mux_share_arbiter (WORD=10, SETTLE_CYC=2). Directed stimulus
// pushes expected captures into a scoreboard; a monitor pops on every VALID.
module tb_mux_share_arbiter;

  localparam int unsigned WORD = 10;

  typedef struct packed {
    logic [3:0]      gnt;
    logic [WORD-1:0] q;
    logic [1:0]      src;
  } exp_t;

  logic            CLK;
  logic            R;
`ifdef MUX_ARB_LOCK_EN
  logic            LOCK;
`endif
  logic [3:0]      REQ;
  logic [WORD-1:0] DA, DB, DC, DD;
  logic [3:0]      SEL, GNT;
  logic            VALID;
  logic [WORD-1:0] Q;
  logic [1:0]      SRC;
  logic            BUSY;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  mux_share_arbiter #(.WORD(10), .SETTLE_CYC(2)) dut (
    .CLK   (CLK),
    .R     (R),
`ifdef MUX_ARB_LOCK_EN
    .LOCK  (LOCK),
`endif
    .REQ   (REQ),
    .DA    (DA),
    .DB    (DB),
    .DC    (DC),
    .DD    (DD),
    .SEL   (SEL),
    .GNT   (GNT),
    .VALID (VALID),
    .Q     (Q),
    .SRC   (SRC),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [WORD-1:0] d, input logic [1:0] s);
    exp_t e;
    e.gnt = g;
    e.q   = d;
    e.src = s;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (GNT != 4'b0) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: no grant within 40 cycles", tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (BUSY == 1'b0) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: BUSY stuck high for 40 cycles", tag);
  endtask

  // Monitor: structural checks every cycle, scoreboard pop on each VALID.
  initial begin
    exp_t e;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("sel_onehot0", 32'($onehot0(SEL)), 32'd1);
      chk("gnt_iff_valid", 32'(GNT != 4'b0), 32'(VALID));
      if (VALID === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got Q=0x%0h SRC=%0d GNT=%b, expected no capture", Q, SRC, GNT);
        end else begin
          e = sb.pop_front();
          chk("cap_gnt", 32'(GNT), 32'(e.gnt));
          chk("cap_q",   32'(Q),   32'(e.q));
          chk("cap_src", 32'(SRC), 32'(e.src));
          chk("cap_sel", 32'(SEL), 32'(e.gnt));
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int last;
    DA = 10'h11A;
    DB = 10'h0B7;
    DC = 10'h0C3;
    DD = 10'h3C0;
    R   = 1'b1;
    REQ = 4'b1111;
`ifdef MUX_ARB_LOCK_EN
    LOCK = 1'b0;
`endif

    // Reset held with all requests active: outputs stay at reset values.
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("rst_sel",   32'(SEL),   32'h0);
      chk("rst_gnt",   32'(GNT),   32'h0);
      chk("rst_valid", 32'(VALID), 32'h0);
      chk("rst_q",     32'(Q),     32'h0);
      chk("rst_busy",  32'(BUSY),  32'h0);
    end

    // Round robin from PTR=0: A,B,C,D,A, one grant every 5 cycles.
    push(4'b1000, 10'h11A, 2'd0);
    push(4'b0100, 10'h0B7, 2'd1);
    push(4'b0010, 10'h0C3, 2'd2);
    push(4'b0001, 10'h3C0, 2'd3);
    push(4'b1000, 10'h11A, 2'd0);
    R = 1'b0;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt("rr_grant");
      if (g > 0) chk("rr_period", 32'(cyc - last), 32'd5);
      last = cyc;
      if (g == 4) begin
        REQ = 4'b0000;
      end else begin
        REQ = 4'b1111 & ~GNT;
        @(negedge CLK);
        REQ = 4'b1111;
      end
    end
    wait_idle("rr_idle");

    // Drop request one cycle into SETTLE: capture still completes (PTR -> 0).
    DD  = 10'h155;
    push(4'b0001, 10'h155, 2'd3);
    REQ = 4'b0001;
    @(negedge CLK);
    REQ = 4'b0000;
    wait_idle("drop_idle");

    // Single request from B with exact cycle-by-cycle timing (PTR -> 2).
    DB  = 10'h2A5;
    push(4'b0100, 10'h2A5, 2'd1);
    REQ = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("single_valid", 32'(VALID), 32'(k == 3));
      chk("single_busy",  32'(BUSY),  32'(k < 4));
      chk("single_sel",   32'(SEL),   (k < 4) ? 32'h4 : 32'h0);
      if (k == 3) REQ = 4'b0000;
    end

    // Reset during SETTLE: aborts with no grant and clears PTR.
    REQ = 4'b0010;
    @(negedge CLK);
    chk("mid_busy", 32'(BUSY), 32'h1);
    chk("mid_sel",  32'(SEL),  32'h2);
    R   = 1'b1;
    REQ = 4'b0000;
    @(negedge CLK);
    chk("mid_rst_sel",   32'(SEL),   32'h0);
    chk("mid_rst_gnt",   32'(GNT),   32'h0);
    chk("mid_rst_valid", 32'(VALID), 32'h0);
    chk("mid_rst_q",     32'(Q),     32'h0);
    chk("mid_rst_src",   32'(SRC),   32'h0);
    chk("mid_rst_busy",  32'(BUSY),  32'h0);
    R   = 1'b0;
    push(4'b1000, 10'h11A, 2'd0);
    REQ = 4'b1010;
    wait_gnt("mid_grant");
    chk("mid_gnt_a", 32'(GNT), 32'h8);
    REQ = 4'b0000;
    wait_idle("mid_idle");

    // Bring PTR back to 0 via a D transaction.
    push(4'b0001, 10'h155, 2'd3);
    REQ = 4'b0001;
    wait_gnt("d_grant");
    REQ = 4'b0000;
    wait_idle("d_idle");

`ifdef MUX_ARB_LOCK_EN
    // LOCK held through the first A grant: A wins again, then D once unlocked.
    LOCK = 1'b1;
    push(4'b1000, 10'h11A, 2'd0);
    push(4'b1000, 10'h11A, 2'd0);
    push(4'b0001, 10'h155, 2'd3);
    REQ = 4'b1001;
    wait_gnt("lock_g1");
    wait_gnt("lock_g2");
    LOCK = 1'b0;
    wait_gnt("lock_g3");
    REQ = 4'b0000;
    wait_idle("lock_idle");
`else
    // Without LOCK the pointer advances: A then D.
    push(4'b1000, 10'h11A, 2'd0);
    push(4'b0001, 10'h155, 2'd3);
    REQ = 4'b1001;
    wait_gnt("nolock_g1");
    wait_gnt("nolock_g2");
    REQ = 4'b0000;
    wait_idle("nolock_idle");
`endif

    repeat (5) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
